// File: rtl/dma_axi_wr.sv
// 1D DMA write request to AXI3/AXI4 write-burst converter on a 32b bus, one burst outstanding.
// Optional 4KB burst splitting is enabled with the macro AXI_WR_4K_SPLIT_EN.
module dma_axi_wr #(
    parameter int MAX_BURST  = 16,
    parameter int WCMD_THRES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_w_req,
    output logic        dma_w_ack,
    input  logic [31:0] dma_w_addr,
    input  logic [15:0] dma_w_len,
    input  logic        dma_w_dvld,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_wbe,
    output logic        dma_w_dack,
    input  logic [5:0]  buf_buf_word,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        wr_busy,
    output logic        wr_err,
    input  logic        clr_wr_err
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B} state_t;

    localparam logic [16:0] MAX_BURST_R = 17'(MAX_BURST);
    localparam logic [8:0]  MAX_BURST_B = 9'(MAX_BURST);
    localparam logic [8:0]  THRES_B     = 9'(WCMD_THRES);

    state_t      state;
    logic [31:0] cur_addr;
    logic [16:0] rem_beats;
    logic [8:0]  burst_beats;
    logic [8:0]  beats_m1;
    logic [8:0]  wcnt;
    logic [8:0]  next_beats;
    logic [8:0]  aw_thres;
    logic        aw_ok;
    logic        in_w;
    logic        w_hs;

    // Beats touched by a request: the start offset inside the first word widens the span.
    function automatic logic [16:0] req_beats(input logic [1:0] ofs, input logic [15:0] len);
        logic [16:0] span;
        span = {15'd0, ofs} + {1'b0, len};
        return (span >> 2) + 17'd1;
    endfunction

`ifdef AXI_WR_4K_SPLIT_EN
    logic [10:0] to4k;
    assign to4k = 11'd1024 - {1'b0, cur_addr[11:2]};
`endif

    always_comb begin
        next_beats = (rem_beats < MAX_BURST_R) ? rem_beats[8:0] : MAX_BURST_B;
`ifdef AXI_WR_4K_SPLIT_EN
        if ({2'b00, next_beats} > to4k) begin
            next_beats = to4k[8:0];
        end
`endif
    end

    // Short bursts only need their own beats buffered before AW goes out.
    assign aw_thres = (burst_beats < THRES_B) ? burst_beats : THRES_B;
    assign aw_ok    = ({3'b000, buf_buf_word} >= aw_thres);
    assign beats_m1 = burst_beats - 9'd1;

    assign in_w       = (state == S_W);
    assign wvalid     = in_w & dma_w_dvld;
    assign dma_w_dack = in_w & wready;
    assign wlast      = in_w & (wcnt == 9'd0);
    assign w_hs       = wvalid & wready;
    assign wdata      = dma_wdata;
    assign wstrb      = dma_wbe;
    assign bready     = (state == S_B);
    assign wr_busy    = (state != S_IDLE);
    assign awsize     = 3'b010;
    assign awburst    = 2'b01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            dma_w_ack   <= 1'b0;
            cur_addr    <= 32'd0;
            rem_beats   <= 17'd0;
            burst_beats <= 9'd0;
            wcnt        <= 9'd0;
            awvalid     <= 1'b0;
            awaddr      <= 32'd0;
            awlen       <= 8'd0;
            wr_err      <= 1'b0;
        end else begin
            dma_w_ack <= 1'b0;
            if (clr_wr_err) begin
                wr_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (dma_w_req) begin
                        dma_w_ack <= 1'b1;
                        cur_addr  <= {dma_w_addr[31:2], 2'b00};
                        rem_beats <= req_beats(dma_w_addr[1:0], dma_w_len);
                        state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    burst_beats <= next_beats;
                    state       <= S_AW;
                end
                S_AW: begin
                    // Once raised, AW is held to the handshake even if the buffer level drops.
                    if (awvalid) begin
                        if (awready) begin
                            awvalid <= 1'b0;
                            wcnt    <= beats_m1;
                            state   <= S_W;
                        end
                    end else if (aw_ok) begin
                        awvalid <= 1'b1;
                        awaddr  <= cur_addr;
                        awlen   <= beats_m1[7:0];
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        if (wcnt == 9'd0) begin
                            cur_addr  <= cur_addr + {21'd0, burst_beats, 2'b00};
                            rem_beats <= rem_beats - {8'd0, burst_beats};
                            state     <= S_B;
                        end else begin
                            wcnt <= wcnt - 9'd1;
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        if (bresp != 2'b00) begin
                            wr_err <= 1'b1;
                        end
                        state <= (rem_beats == 17'd0) ? S_IDLE : S_CALC;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_axi_wr.sv
// Directed bench for dma_axi_wr: AW and W scoreboards filled from a burst-split model at request time.
// Follows AXI_WR_4K_SPLIT_EN in the same way as the design build.
module tb_dma_axi_wr;

    localparam int MAXB  = 16;
    localparam int THRES = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_w_req;
    logic        dma_w_ack;
    logic [31:0] dma_w_addr;
    logic [15:0] dma_w_len;
    logic        dma_w_dvld;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_wbe;
    logic        dma_w_dack;
    logic [5:0]  buf_buf_word;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        wr_busy;
    logic        wr_err;
    logic        clr_wr_err;

    always #5 clk = ~clk;

    dma_axi_wr #(.MAX_BURST(MAXB), .WCMD_THRES(THRES)) dut (
        .clk(clk), .rst(rst),
        .dma_w_req(dma_w_req), .dma_w_ack(dma_w_ack),
        .dma_w_addr(dma_w_addr), .dma_w_len(dma_w_len),
        .dma_w_dvld(dma_w_dvld), .dma_wdata(dma_wdata), .dma_wbe(dma_wbe),
        .dma_w_dack(dma_w_dack), .buf_buf_word(buf_buf_word),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .wr_busy(wr_busy), .wr_err(wr_err), .clr_wr_err(clr_wr_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    aw_t aw_exp[$];
    w_t  w_exp[$];
    int  errors = 0;
    int  checks = 0;
    int  src_idx = 0;
    int  exp_idx = 0;
    bit  rnd = 1'b0;
    bit  err_once = 1'b0;

    function automatic logic [31:0] gen_data(input int idx);
        return 32'hC0DE_0000 ^ (32'(idx) * 32'h0101_0107);
    endfunction

    function automatic logic [3:0] gen_be(input int idx);
        return 4'((idx * 5) + 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Split a request into the expected bursts and beats.
    task automatic push_model(input logic [31:0] addr, input logic [15:0] len);
        logic [31:0] a;
        int beats;
        a = {addr[31:2], 2'b00};
        beats = ((int'(addr[1:0]) + int'(len)) >> 2) + 1;
        while (beats > 0) begin
            int b;
            b = (beats < MAXB) ? beats : MAXB;
`ifdef AXI_WR_4K_SPLIT_EN
            begin
                int t;
                t = (4096 - int'(a[11:0])) / 4;
                if (t < b) b = t;
            end
`endif
            aw_exp.push_back('{addr: a, len: 8'(b - 1)});
            for (int k = 0; k < b; k++) begin
                w_exp.push_back('{data: gen_data(exp_idx), strb: gen_be(exp_idx), last: (k == b - 1)});
                exp_idx++;
            end
            a = a + 32'(b * 4);
            beats = beats - b;
        end
    endtask

    // Sample handshakes at the falling edge, update sources just after the rising edge.
    task automatic tick();
        bit took;
        bit bhs;
        aw_t ea;
        w_t  ew;
        @(negedge clk);
        if (awvalid && awready) begin
            if (aw_exp.size() == 0) begin
                chk("aw_unexpected", 32'(awvalid), 32'd0);
            end else begin
                ea = aw_exp.pop_front();
                chk("awaddr", awaddr, ea.addr);
                chk("awlen", 32'(awlen), 32'(ea.len));
            end
        end
        if (wvalid && wready) begin
            if (w_exp.size() == 0) begin
                chk("w_unexpected", 32'(wvalid), 32'd0);
            end else begin
                ew = w_exp.pop_front();
                chk("wdata", wdata, ew.data);
                chk("wstrb", 32'(wstrb), 32'(ew.strb));
                chk("wlast", 32'(wlast), 32'(ew.last));
            end
        end
        if (dma_w_dack) chk("dack_needs_wready", 32'(wready), 32'd1);
        took = dma_w_dvld && dma_w_dack;
        bhs  = bvalid && bready;
        @(posedge clk);
        #1;
        if (took) begin
            src_idx++;
            dma_wdata = gen_data(src_idx);
            dma_wbe   = gen_be(src_idx);
        end
        if (bhs && err_once) begin
            bresp    = 2'b00;
            err_once = 1'b0;
        end
        if (rnd) begin
            dma_w_dvld = ($urandom_range(0, 3) != 0);
            wready     = $urandom_range(0, 1) == 1;
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [15:0] l);
        push_model(a, l);
        dma_w_addr = a;
        dma_w_len  = l;
        dma_w_req  = 1'b1;
        tick();
        chk("ack_pulse", 32'(dma_w_ack), 32'd1);
        chk("busy_after_ack", 32'(wr_busy), 32'd1);
        dma_w_req = 1'b0;
        tick();
        chk("ack_one_cycle", 32'(dma_w_ack), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (wr_busy && n < 600) begin
            tick();
            n++;
        end
        chk(tag, 32'(wr_busy), 32'd0);
        chk("aw_left", 32'(aw_exp.size()), 32'd0);
        chk("w_left", 32'(w_exp.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        dma_w_req = 1'b0; dma_w_addr = '0; dma_w_len = '0;
        dma_w_dvld = 1'b1; dma_wdata = gen_data(0); dma_wbe = gen_be(0);
        buf_buf_word = 6'd20; awready = 1'b1; wready = 1'b1;
        bvalid = 1'b1; bresp = 2'b00; clr_wr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_ack", 32'(dma_w_ack), 32'd0);
        chk("rst_dack", 32'(dma_w_dack), 32'd0);
        chk("rst_busy", 32'(wr_busy), 32'd0);
        chk("rst_err", 32'(wr_err), 32'd0);
        chk("rst_awsize", 32'(awsize), 32'd2);
        chk("rst_awburst", 32'(awburst), 32'd1);
        rst = 1'b0;
        tick();

        // single 16-beat burst at 0x1000
        do_req(32'h0000_1000, 16'd63);
        wait_idle("t1_idle");

        // unaligned start, 26 beats in two bursts, throttled data and wready
        rnd = 1'b1;
        do_req(32'h0000_2002, 16'd99);
        wait_idle("t2_idle");
        rnd = 1'b0; dma_w_dvld = 1'b1; wready = 1'b1;

        // 4KB crossing
        do_req(32'h0000_0FFC, 16'd7);
        wait_idle("t3_idle");

        // buffer-level gating of AW, held request ignored while busy
        buf_buf_word = 6'd5;
        awready = 1'b0;
        do_req(32'h0000_3000, 16'd63);
        dma_w_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_req_no_ack", 32'(dma_w_ack), 32'd0);
        end
        dma_w_req = 1'b0;
        repeat (2) tick();
        chk("aw_gated_low_buf", 32'(awvalid), 32'd0);
        buf_buf_word = 6'd12;
        tick();
        chk("aw_after_thres", 32'(awvalid), 32'd1);
        buf_buf_word = 6'd0;
        repeat (2) tick();
        chk("aw_held_after_drop", 32'(awvalid), 32'd1);
        awready = 1'b1;
        wait_idle("t4_idle");

        // short burst needs only its own beats buffered
        buf_buf_word = 6'd3;
        do_req(32'h0000_4000, 16'd11);
        wait_idle("t4b_idle");
        buf_buf_word = 6'd20;

        // error response on first of two bursts
        bresp = 2'b10;
        err_once = 1'b1;
        do_req(32'h0000_5000, 16'd127);
        wait_idle("t5_idle");
        chk("err_sticky", 32'(wr_err), 32'd1);
        clr_wr_err = 1'b1;
        tick();
        clr_wr_err = 1'b0;
        chk("err_cleared", 32'(wr_err), 32'd0);

        // reset while W is stalled
        wready = 1'b0;
        do_req(32'h0000_6000, 16'd15);
        begin
            int n;
            n = 0;
            while (!wvalid && n < 50) begin
                tick();
                n++;
            end
            chk("reach_w", 32'(wvalid), 32'd1);
        end
        rst = 1'b1;
        wready = 1'b1;
        #1;
        chk("midrst_wvalid", 32'(wvalid), 32'd0);
        chk("midrst_awvalid", 32'(awvalid), 32'd0);
        chk("midrst_bready", 32'(bready), 32'd0);
        chk("midrst_dack", 32'(dma_w_dack), 32'd0);
        chk("midrst_busy", 32'(wr_busy), 32'd0);
        aw_exp.delete();
        w_exp.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(wr_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_axi_wr.md
Name: dma_axi_wr

Overview:
- Downstream stage of the 1D DMA write-command generator.
- Accepts 1D write requests (byte address, byte length) and the re-aligned 32b data/byte-enable stream.
- Converts them into AXI3/AXI4 write bursts on a 32b bus: splits on max-burst and 4KB boundaries, gates AW issue on buffered data level, and collects B responses.

Parameters:
- MAX_BURST, 16, maximum beats per AXI burst (1..256).
- WCMD_THRES, 12, buffered 32b words required before AW issue, unless the burst is shorter than this.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- dma_w_req  in  1  1D write request
- dma_w_ack  out  1  request accepted; 1T pulse
- dma_w_addr  in  32  start byte address
- dma_w_len  in  16  byte length, counts from 0
- dma_w_dvld  in  1  data beat valid
- dma_wdata  in  32  write data
- dma_wbe  in  4  byte enables for dma_wdata
- dma_w_dack  out  1  data beat consumed
- buf_buf_word  in  6  32b words buffered upstream
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- awaddr  out  32  burst address, word-aligned
- awlen  out  8  beats-1
- awsize  out  3  constant 3'b010
- awburst  out  2  constant 2'b01 (INCR)
- wvalid  out  1  W valid
- wready  in  1  W ready
- wdata  out  32  = dma_wdata
- wstrb  out  4  = dma_wbe
- wlast  out  1  last beat of burst
- bvalid  in  1  B valid
- bready  out  1  B ready
- bresp  in  2  write response
- wr_busy  out  1  request in progress
- wr_err  out  1  sticky, set on non-OKAY bresp
- clr_wr_err  in  1  clears wr_err

Behaviour:
- Reset: state S_IDLE. All outputs 0 except the constants awsize=3'b010 and awburst=2'b01. Internal counters 0.
- Reset mid-operation aborts everything at once: no AW/W/B valid/ready remains asserted, and there is no recovery handshake.

States:
- S_IDLE: when dma_w_req=1, pulse dma_w_ack for 1 cycle. Latch:
  - cur_addr = {dma_w_addr[31:2], 2'b00}
  - rem_beats (17b) = ((dma_w_addr[1:0] + dma_w_len) >> 2) + 1
  - Go to S_CALC.
- S_CALC: compute, for 1 cycle, into burst_beats:
  - to4k = (4096 - cur_addr[11:0]) >> 2
  - burst_beats = min(rem_beats, MAX_BURST, to4k)
  - Go to S_AW.
- S_AW:
  - awvalid asserts only once buf_buf_word >= min(burst_beats, WCMD_THRES).
  - awaddr = cur_addr; awlen = burst_beats - 1.
  - Once asserted, awvalid and the AW payload hold until awready.
  - On handshake: load wcnt = burst_beats - 1 and go to S_W.
- S_W:
  - wvalid = dma_w_dvld; dma_w_dack = wready; both forced 0 outside S_W.
  - wlast = (wcnt == 0).
  - Each wvalid&wready: wcnt decrements.
  - On the wlast beat: go to S_B; cur_addr += burst_beats*4; rem_beats -= burst_beats.
- S_B: bready=1.
  - On bvalid: if bresp != 2'b00, set wr_err.
  - If rem_beats == 0, go to S_IDLE; otherwise go to S_CALC.
- Only one burst is outstanding; there is no AW/W overlap.
- wr_busy = (state != S_IDLE).
- wr_err:
  - Set has priority over clr_wr_err in the same cycle.
  - The burst sequence continues after an error; no abort.
- Boundaries:
  - A 1-byte request gives 1 beat.
  - Address ...FFC with length 7 crosses 4KB and gives two 1-beat bursts: FFC then 1000 (with 4KB split enabled).
  - A buf_buf_word drop after AW has issued does not retract AW.
  - A new dma_w_req is ignored (no ack) until S_IDLE.

Optional Feature:
- Macro AXI_WR_4K_SPLIT_EN.
- Defined: to4k is included in the burst_beats minimum, so no burst crosses a 4KB boundary.
- Undefined: burst_beats = min(rem_beats, MAX_BURST); to4k logic is absent. System guarantees 4KB-safe transfers.

Test Plan:
- addr=0x1000, len=63, data always valid, wready=1, buf_buf_word=20 -> ack pulse; 1 burst: awaddr=0x1000, awlen=15; 16 beats, wlast on beat 16; wr_busy low 1 cycle after bvalid.
- addr=0x2002, len=99 -> beats=26; bursts awaddr 0x2000 awlen=15, then 0x2040 awlen=9; wstrb passes through unmodified.
- addr=0x0FFC, len=7, macro defined -> bursts 0x0FFC awlen=0 and 0x1000 awlen=0. Macro undefined -> one burst 0x0FFC awlen=1.
- buf_buf_word=5, burst 16 beats -> awvalid stays 0. Raise buf_buf_word to 12 -> awvalid next cycle. Burst of 3 beats with buf_buf_word=3 -> issues.
- wready toggling 1/0 and dma_w_dvld gaps -> no beat lost or duplicated; dma_w_dack only when wready=1 in S_W.
- bresp=2'b10 on first of two bursts -> wr_err=1, second burst still issued. clr_wr_err pulse -> wr_err=0. rst asserted mid S_W -> all valids 0 immediately.
